// File: rtl/stage_if.sv
// Instruction-fetch stage: program counter, fetch request/grant towards
// instruction memory, in-order response capture into a small queue, and
// presentation of one instruction per cycle to decode. A redirect from
// execute flushes the queue; responses still in flight for flushed fetches
// are counted and silently dropped when they come back.
module stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_jump_en,
  input  logic [31:0] i_jump_addr,
  input  logic        i_stall,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_addr,
  output logic        o_inst_valid
);

  // Pointer width, allocation-count width and discard-counter width.
  // The discard counter carries two extra bits: back-to-back redirects can
  // stack stale responses from more than one flushed window.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int DW = PW + 3;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Architectural fetch state
  logic [31:0]      pc_r;
  logic [31:0]      addr_q_r [DEPTH];
  logic [31:0]      data_q_r [DEPTH];
  logic [DEPTH-1:0] filled_r;
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [PW-1:0]    fill_r;
  logic [CW-1:0]    alloc_cnt_r;
  logic [CW-1:0]    unfilled_cnt_r;
  logic [DW-1:0]    discard_r;

  // Next-state values
  logic [31:0]      pc_n_s;
  logic [PW-1:0]    head_n_s;
  logic [PW-1:0]    tail_n_s;
  logic [PW-1:0]    fill_n_s;
  logic [CW-1:0]    alloc_cnt_n_s;
  logic [CW-1:0]    unfilled_cnt_n_s;
  logic [DW-1:0]    discard_n_s;

  // Per-cycle events
  logic             full_s;
  logic             req_s;
  logic             grant_s;
  logic             head_valid_s;
  logic             pop_s;
  logic             drop_s;
  logic             fill_s;
  logic [DW-1:0]    outstanding_s;
  logic [31:0]      jump_target_s;

  // Event decode: request, grant, pop, response routing
  always_comb begin
    full_s        = (alloc_cnt_r == CW'(DEPTH));
    req_s         = i_rst_n & ~full_s & ~i_jump_en;
    grant_s       = req_s & i_imem_gnt;
    head_valid_s  = (alloc_cnt_r != {CW{1'b0}}) & filled_r[head_r];
    pop_s         = head_valid_s & ~i_stall & ~i_jump_en;
    drop_s        = i_imem_rvalid & (discard_r != {DW{1'b0}}) & ~i_jump_en;
    fill_s        = i_imem_rvalid & (discard_r == {DW{1'b0}}) &
                    (unfilled_cnt_r != {CW{1'b0}}) & ~i_jump_en;
    outstanding_s = discard_r + DW'(unfilled_cnt_r);
    jump_target_s = i_jump_addr & 32'hFFFF_FFFC;
  end

  // Next-state computation for PC, pointers and counters; redirect wins
  always_comb begin
    pc_n_s           = pc_r;
    head_n_s         = head_r;
    tail_n_s         = tail_r;
    fill_n_s         = fill_r;
    alloc_cnt_n_s    = alloc_cnt_r;
    unfilled_cnt_n_s = unfilled_cnt_r;
    discard_n_s      = discard_r;
    if (i_jump_en) begin
      pc_n_s           = jump_target_s;
      head_n_s         = {PW{1'b0}};
      tail_n_s         = {PW{1'b0}};
      fill_n_s         = {PW{1'b0}};
      alloc_cnt_n_s    = {CW{1'b0}};
      unfilled_cnt_n_s = {CW{1'b0}};
      // A response arriving this cycle is absorbed by the flush itself.
      if (i_imem_rvalid && (outstanding_s != {DW{1'b0}})) begin
        discard_n_s = outstanding_s - DW'(1);
      end else begin
        discard_n_s = outstanding_s;
      end
    end else begin
      if (grant_s) begin
        pc_n_s   = pc_r + 32'd4;
        tail_n_s = tail_r + PW'(1);
      end else begin
        pc_n_s   = pc_r;
        tail_n_s = tail_r;
      end
      if (pop_s) begin
        head_n_s = head_r + PW'(1);
      end else begin
        head_n_s = head_r;
      end
      if (fill_s) begin
        fill_n_s = fill_r + PW'(1);
      end else begin
        fill_n_s = fill_r;
      end
      if (drop_s) begin
        discard_n_s = discard_r - DW'(1);
      end else begin
        discard_n_s = discard_r;
      end
      alloc_cnt_n_s    = alloc_cnt_r + CW'(grant_s) - CW'(pop_s);
      unfilled_cnt_n_s = unfilled_cnt_r + CW'(grant_s) - CW'(fill_s);
    end
  end

  // PC, pointer and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_r           <= RESET_PC;
      head_r         <= {PW{1'b0}};
      tail_r         <= {PW{1'b0}};
      fill_r         <= {PW{1'b0}};
      alloc_cnt_r    <= {CW{1'b0}};
      unfilled_cnt_r <= {CW{1'b0}};
      discard_r      <= {DW{1'b0}};
    end else begin
      pc_r           <= pc_n_s;
      head_r         <= head_n_s;
      tail_r         <= tail_n_s;
      fill_r         <= fill_n_s;
      alloc_cnt_r    <= alloc_cnt_n_s;
      unfilled_cnt_r <= unfilled_cnt_n_s;
      discard_r      <= discard_n_s;
    end
  end

  // Filled flags: cleared on allocate or flush, set when the response lands
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filled_r <= {DEPTH{1'b0}};
    end else if (i_jump_en) begin
      filled_r <= {DEPTH{1'b0}};
    end else begin
      // The tail slot is free and the fill slot is allocated, so the two
      // indices never coincide in the same cycle.
      if (grant_s) begin
        filled_r[tail_r] <= 1'b0;
      end
      if (fill_s) begin
        filled_r[fill_r] <= 1'b1;
      end
    end
  end

  // Queue payload: address captured at grant, instruction word at response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q_r[i] <= 32'h0000_0000;
        data_q_r[i] <= 32'h0000_0000;
      end
    end else begin
      if (grant_s) begin
        addr_q_r[tail_r] <= pc_r;
      end
      if (fill_s) begin
        data_q_r[fill_r] <= i_imem_rdata;
      end
    end
  end

  // Output drive: request is gated by redirect, decode sees head or a NOP
  always_comb begin
    o_imem_req   = req_s;
    o_imem_addr  = pc_r;
    o_inst_valid = head_valid_s;
    if (head_valid_s) begin
      o_inst      = data_q_r[head_r];
      o_inst_addr = addr_q_r[head_r];
    end else begin
      o_inst      = NOP_INST;
      o_inst_addr = 32'h0000_0000;
    end
  end

endmodule
